// File: rtl/graph_isa_pkg.sv
// graph_isa_pkg: shared types for the graph ISA engines and their arbiters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: slice_cmd_t descriptor, SLICE_CMD_W, slice arbiter state enum.
package graph_isa_pkg;

    localparam int SLICE_CMD_W = 96;

    // Slice engine descriptor, MSB first as it sits on the request bus.
    typedef struct packed {
        logic [15:0] src_base;
        logic [15:0] dst_base;
        logic [15:0] src_row_len;
        logic [15:0] dst_row_len;
        logic [15:0] start_offset;
        logic [15:0] num_rows;
    } slice_cmd_t;

    typedef enum logic [2:0] {
        AR_IDLE,
        AR_CHECK,
        AR_ISSUE,
        AR_WAIT,
        AR_RESP
    } sa_state_t;

endpackage

// File: rtl/graph_rr_arbiter.sv
// graph_rr_arbiter: N-way round-robin pick, search starts one past ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
// Ports: req (request vector), ptr (last winner), grant (one-hot),
//        idx (winner index), any (at least one request).
module graph_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk ptr+1, ptr+2, ... ptr+N (mod N); the first hit wins, so the
        // previous winner is considered last.
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k + 1) % N]) begin
                any = 1'b1;
                grant[(int'(ptr) + k + 1) % N] = 1'b1;
                idx = IDX_W'((int'(ptr) + k + 1) % N);
            end
        end
    end

endmodule

// File: rtl/slice_arbiter.sv
// slice_arbiter: shares one slice_engine between N_REQ requesters (round-robin).
// Latency: accept edge T -> eng_cmd_valid sampled at T+2; reject -> rsp_done at T+2;
//          rsp_done one cycle after eng_done. Backpressure: one command in flight,
//          req_ready only in AR_IDLE; issue holds while eng_busy is high.
// Ports: req_valid/req_ready/req_cmd per requester, rsp_done/rsp_err pulse to the
//        owner, eng_* command to the engine, eng_busy/eng_done back, busy, grant_id.
// Optional macro SLICE_ARB_PERF_EN adds perf_cmd_cnt, perf_busy_cyc, perf_rej_cnt.
module slice_arbiter
    import graph_isa_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*SLICE_CMD_W-1:0] req_cmd,
    output logic [N_REQ-1:0]           rsp_done,
    output logic [N_REQ-1:0]           rsp_err,
    output logic                       eng_cmd_valid,
    output logic [15:0]                eng_src_base,
    output logic [15:0]                eng_dst_base,
    output logic [15:0]                eng_src_row_len,
    output logic [15:0]                eng_dst_row_len,
    output logic [15:0]                eng_start_offset,
    output logic [15:0]                eng_num_rows,
    input  logic                       eng_busy,
    input  logic                       eng_done,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id
`ifdef SLICE_ARB_PERF_EN
    ,
    output logic [31:0]                perf_cmd_cnt,
    output logic [31:0]                perf_busy_cyc,
    output logic [15:0]                perf_rej_cnt
`endif
);

    sa_state_t   r_state;
    slice_cmd_t  r_cmd;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_rr_ptr;
    logic        r_err;

    logic [N_REQ-1:0] w_rr_grant;
    logic [ID_W-1:0]  w_rr_idx;
    logic             w_rr_any;
    slice_cmd_t       w_cmd_sel;
    logic [16:0]      w_end;
    logic             w_reject;
    logic             w_issue;

    graph_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_rr_grant),
        .idx   (w_rr_idx),
        .any   (w_rr_any)
    );

    assign w_cmd_sel = req_cmd[int'(w_rr_idx)*SLICE_CMD_W +: SLICE_CMD_W];

    // 17-bit end offset so a wrap past 0xFFFF is still seen as out of range.
    // Zero lengths are screened because the engine's length-1 compare underflows.
    assign w_end    = {1'b0, r_cmd.start_offset} + {1'b0, r_cmd.dst_row_len};
    assign w_reject = (r_cmd.num_rows == 16'd0) || (r_cmd.dst_row_len == 16'd0) ||
                      (w_end > {1'b0, r_cmd.src_row_len});

    assign w_issue  = (r_state == AR_ISSUE) && !eng_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= AR_IDLE;
            r_cmd      <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= ID_W'(N_REQ - 1);
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                AR_IDLE: begin
                    if (w_rr_any) begin
                        r_cmd      <= w_cmd_sel;
                        r_grant_id <= w_rr_idx;
                        r_rr_ptr   <= w_rr_idx;
                        r_state    <= AR_CHECK;
                    end
                end
                AR_CHECK: begin
                    r_err   <= w_reject;
                    r_state <= w_reject ? AR_RESP : AR_ISSUE;
                end
                AR_ISSUE: begin
                    if (w_issue) begin
                        r_state <= AR_WAIT;
                    end
                end
                AR_WAIT: begin
                    if (eng_done) begin
                        r_err   <= 1'b0;
                        r_state <= AR_RESP;
                    end
                end
                AR_RESP: begin
                    r_state <= AR_IDLE;
                end
                default: begin
                    r_state <= AR_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = (r_state == AR_IDLE) ? w_rr_grant : '0;
    assign eng_cmd_valid    = w_issue;
    assign eng_src_base     = r_cmd.src_base;
    assign eng_dst_base     = r_cmd.dst_base;
    assign eng_src_row_len  = r_cmd.src_row_len;
    assign eng_dst_row_len  = r_cmd.dst_row_len;
    assign eng_start_offset = r_cmd.start_offset;
    assign eng_num_rows     = r_cmd.num_rows;
    assign busy             = (r_state != AR_IDLE);
    assign grant_id         = r_grant_id;

    always_comb begin
        rsp_done = '0;
        rsp_err  = '0;
        if (r_state == AR_RESP) begin
            rsp_done[r_grant_id] = 1'b1;
            rsp_err[r_grant_id]  = r_err;
        end
    end

`ifdef SLICE_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cmd_cnt  <= '0;
            perf_busy_cyc <= '0;
            perf_rej_cnt  <= '0;
        end else begin
            if (r_state == AR_RESP && !r_err && perf_cmd_cnt != '1) begin
                perf_cmd_cnt <= perf_cmd_cnt + 32'd1;
            end
            if (r_state == AR_RESP && r_err && perf_rej_cnt != '1) begin
                perf_rej_cnt <= perf_rej_cnt + 16'd1;
            end
            if (busy && perf_busy_cyc != '1) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_slice_arbiter.sv
// tb_slice_arbiter: directed self-checking bench for slice_arbiter.
// Latency: n/a. Backpressure: bench plays the engine via eng_busy/eng_done.
// Covers reset, round-robin order, screening, busy hold, mid-op reset.
module tb_slice_arbiter;
    import graph_isa_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          req_valid = '0;
    logic [N-1:0]          req_ready;
    logic [N*96-1:0]       req_cmd = '0;
    logic [N-1:0]          rsp_done;
    logic [N-1:0]          rsp_err;
    logic                  eng_cmd_valid;
    logic [15:0]           eng_src_base, eng_dst_base, eng_src_row_len;
    logic [15:0]           eng_dst_row_len, eng_start_offset, eng_num_rows;
    logic                  eng_busy = 1'b0;
    logic                  eng_done = 1'b0;
    logic                  busy;
    logic [IW-1:0]         grant_id;
`ifdef SLICE_ARB_PERF_EN
    logic [31:0]           perf_cmd_cnt;
    logic [31:0]           perf_busy_cyc;
    logic [15:0]           perf_rej_cnt;
`endif

    always #5 clk = ~clk;

    slice_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cmd          (req_cmd),
        .rsp_done         (rsp_done),
        .rsp_err          (rsp_err),
        .eng_cmd_valid    (eng_cmd_valid),
        .eng_src_base     (eng_src_base),
        .eng_dst_base     (eng_dst_base),
        .eng_src_row_len  (eng_src_row_len),
        .eng_dst_row_len  (eng_dst_row_len),
        .eng_start_offset (eng_start_offset),
        .eng_num_rows     (eng_num_rows),
        .eng_busy         (eng_busy),
        .eng_done         (eng_done),
        .busy             (busy),
        .grant_id         (grant_id)
`ifdef SLICE_ARB_PERF_EN
        ,
        .perf_cmd_cnt     (perf_cmd_cnt),
        .perf_busy_cyc    (perf_busy_cyc),
        .perf_rej_cnt     (perf_rej_cnt)
`endif
    );

    wire [95:0] w_eng = {eng_src_base, eng_dst_base, eng_src_row_len,
                         eng_dst_row_len, eng_start_offset, eng_num_rows};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slice_cmd_t mk(input logic [15:0] sb, input logic [15:0] db,
                                      input logic [15:0] sl, input logic [15:0] dl,
                                      input logic [15:0] so, input logic [15:0] nr);
        slice_cmd_t c;
        c.src_base     = sb;
        c.dst_base     = db;
        c.src_row_len  = sl;
        c.dst_row_len  = dl;
        c.start_offset = so;
        c.num_rows     = nr;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a ready, checks which one, then takes the accept edge.
    task automatic wait_accept(input string tag, input logic [N-1:0] exp_ready);
        int k;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            tick();
            k++;
        end
        check({tag, " ready"}, req_ready, exp_ready);
        tick();
    endtask

    // Called #1 after the accept edge; walks the command to its response.
    task automatic serve(input string tag, input int id, input bit exp_err,
                         input slice_cmd_t exp, input int busy_cyc);
        logic [N-1:0] oh;
        oh = 4'b0001 << id;
        eng_busy = (busy_cyc > 0);
        check({tag, " grant"}, grant_id, id);
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " no ready"}, req_ready, '0);
        check({tag, " ecv chk"}, eng_cmd_valid, 1'b0);
        check({tag, " fields"}, w_eng, exp);
        tick();
        if (exp_err) begin
            check({tag, " ecv rej"}, eng_cmd_valid, 1'b0);
            check({tag, " done"}, rsp_done, oh);
            check({tag, " err"}, rsp_err, oh);
            tick();
        end else begin
            for (int b = 0; b < busy_cyc; b++) begin
                check({tag, " ecv held"}, eng_cmd_valid, 1'b0);
                tick();
            end
            eng_busy = 1'b0;
            #1;
            check({tag, " ecv"}, eng_cmd_valid, 1'b1);
            check({tag, " fields issue"}, w_eng, exp);
            tick();
            check({tag, " ecv one"}, eng_cmd_valid, 1'b0);
            check({tag, " wait done"}, rsp_done, '0);
            tick();
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            check({tag, " done"}, rsp_done, oh);
            check({tag, " err"}, rsp_err, '0);
            tick();
        end
        check({tag, " idle"}, busy, 1'b0);
        check({tag, " done clr"}, rsp_done, '0);
        check({tag, " hold id"}, grant_id, id);
    endtask

    slice_cmd_t c;
    slice_cmd_t rr_cmd [N];
    logic [N-1:0] rr_exp [5];

    initial begin
        #1;
        check("rst ready", req_ready, '0);
        check("rst done", rsp_done, '0);
        check("rst ecv", eng_cmd_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst grant", grant_id, '0);
        check("rst fields", w_eng, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Round-robin with all four held valid: 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            rr_cmd[i] = mk(16'h1000 * 16'(i + 1), 16'h0800, 16'd8, 16'd4, 16'd2, 16'd3);
            req_cmd[i*96 +: 96] = rr_cmd[i];
        end
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            int id;
            id = (g == 4) ? 0 : g;
            wait_accept("rr", rr_exp[g]);
            if (g == 4) req_valid = '0;
            serve("rr", id, 1'b0, rr_cmd[id], 0);
        end

        // Single request on req0; bus changes after accept must not leak in.
        c = mk(16'h0100, 16'h0800, 16'd8, 16'd4, 16'd2, 16'd3);
        req_cmd[0 +: 96] = c;
        req_valid = 4'b0001;
        #1;
        wait_accept("single", 4'b0001);
        req_valid = '0;
        req_cmd[0 +: 96] = {6{16'hDEAD}};
        serve("single", 0, 1'b0, c, 0);

        // Degenerate commands on req1.
        c = mk(16'h0200, 16'h0900, 16'd8, 16'd4, 16'd0, 16'd0);
        req_cmd[96 +: 96] = c;
        req_valid = 4'b0010;
        #1;
        wait_accept("rows0", 4'b0010);
        req_valid = '0;
        serve("rows0", 1, 1'b1, c, 0);

        c = mk(16'h0200, 16'h0900, 16'd8, 16'd0, 16'd0, 16'd2);
        req_cmd[96 +: 96] = c;
        req_valid = 4'b0010;
        #1;
        wait_accept("dlen0", 4'b0010);
        req_valid = '0;
        serve("dlen0", 1, 1'b1, c, 0);

        // Range boundary: 6+3 > 8 rejected, 6+2 == 8 accepted.
        c = mk(16'h0300, 16'h0A00, 16'd8, 16'd3, 16'd6, 16'd1);
        req_cmd[96 +: 96] = c;
        req_valid = 4'b0010;
        #1;
        wait_accept("oor", 4'b0010);
        req_valid = '0;
        serve("oor", 1, 1'b1, c, 0);

        c = mk(16'h0300, 16'h0A00, 16'd8, 16'd2, 16'd6, 16'd1);
        req_cmd[96 +: 96] = c;
        req_valid = 4'b0010;
        #1;
        wait_accept("edge", 4'b0010);
        req_valid = '0;
        serve("edge", 1, 1'b0, c, 0);

        // Sum wraps 16 bits (0xFFFF+2); must still be rejected.
        c = mk(16'h0400, 16'h0B00, 16'hFFFF, 16'd2, 16'hFFFF, 16'd1);
        req_cmd[2*96 +: 96] = c;
        req_valid = 4'b0100;
        #1;
        wait_accept("wrap", 4'b0100);
        req_valid = '0;
        serve("wrap", 2, 1'b1, c, 0);

        // Engine busy for 5 cycles on entry to issue.
        c = mk(16'h0500, 16'h0C00, 16'd16, 16'd4, 16'd4, 16'd2);
        req_cmd[3*96 +: 96] = c;
        req_valid = 4'b1000;
        #1;
        wait_accept("engbusy", 4'b1000);
        req_valid = '0;
        serve("engbusy", 3, 1'b0, c, 5);

        // Stray eng_done while idle is ignored.
        eng_done = 1'b1;
        #1;
        check("stray done", rsp_done, '0);
        tick();
        eng_done = 1'b0;
        check("stray busy", busy, 1'b0);

`ifdef SLICE_ARB_PERF_EN
        check("perf cmd", perf_cmd_cnt, 32'd8);
        check("perf rej", perf_rej_cnt, 16'd4);
`endif

        // Reset during AR_WAIT.
        c = mk(16'h0600, 16'h0D00, 16'd8, 16'd4, 16'd1, 16'd1);
        req_cmd[2*96 +: 96] = c;
        req_valid = 4'b0100;
        #1;
        wait_accept("mid", 4'b0100);
        req_valid = '0;
        tick();
        check("mid ecv", eng_cmd_valid, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst grant", grant_id, '0);
        check("mid rst fields", w_eng, '0);
        check("mid rst ecv", eng_cmd_valid, 1'b0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("mid rst done", rsp_done, '0);
`ifdef SLICE_ARB_PERF_EN
        check("perf cmd rst", perf_cmd_cnt, 32'd0);
        check("perf busy rst", perf_busy_cyc, 32'd0);
        check("perf rej rst", perf_rej_cnt, 16'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("post rst done", rsp_done, '0);
        check("post rst busy", busy, 1'b0);

        req_valid = 4'b0100;
        #1;
        wait_accept("after", 4'b0100);
        req_valid = '0;
        serve("after", 2, 1'b0, c, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
